// File: rtl/regfile_wb_unit.sv
// regfile_wb_unit: register-file front end for the single-issue MIPS core.
//   Decodes rs/rt/destination from the instruction, reads two operands,
//   extends the 16-bit immediate, registers writeback one stage behind decode
//   and tracks a single outstanding load whose data arrives later.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   instr                 rs=[25:21] rt=[20:16] rd=[15:11] imm=[15:0]
//   reg_write, reg_dst    write enable, destination select (0 rt,1 rd,2 link)
//   mem_to_reg, ext_mode  result select (0 alu,1 load,2 pc+4), imm extension
//   alu_result, read_data, mem_valid, pc_plus4   writeback sources
//   src_a, write_data     rs / rt operands
//   imm_ext               extended immediate
//   stall                 decode must hold instr this cycle
//
// Build option: define REGFILE_BYPASS_EN to forward the writeback stage to
// the read ports; without it, readers of the staged register stall one cycle.

module regfile_wb_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned LINK_REG = NUM_REGS - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              reg_write,
  input  logic [1:0]        reg_dst,
  input  logic [1:0]        mem_to_reg,
  input  logic              ext_mode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] src_a,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic              stall
);

  localparam int unsigned ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic {LD_IDLE, LD_WAIT} ld_state_t;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  ld_state_t         ld_state_q, ld_state_d;
  addr_t             pend_addr_q, pend_addr_d;
  logic              stage_valid_q, stage_valid_d;
  addr_t             stage_addr_q, stage_addr_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;

  addr_t             rs_addr, rt_addr, rd_addr, dest;
  logic              pending, mem_accept, is_load, wr_req, wr_issue;
  logic              pend_hazard, stage_hazard;
  logic [DATA_W-1:0] wb_result;
  logic              unused_instr;

  assign rs_addr      = instr[21 +: ADDR_W];
  assign rt_addr      = instr[16 +: ADDR_W];
  assign rd_addr      = instr[11 +: ADDR_W];
  assign unused_instr = ^instr;

  always_comb begin
    case (reg_dst)
      2'd1:    dest = rd_addr;
      2'd2:    dest = addr_t'(LINK_REG);
      default: dest = rt_addr;
    endcase
  end

  always_comb begin
    imm_ext       = {DATA_W{ext_mode ? 1'b0 : instr[15]}};
    imm_ext[15:0] = instr[15:0];
  end

  assign wb_result  = (mem_to_reg == 2'd2) ? pc_plus4 : alu_result;
  assign pending    = (ld_state_q == LD_WAIT);
  assign mem_accept = pending & mem_valid;
  assign is_load    = (mem_to_reg == 2'd1);
  assign wr_req     = reg_write & (dest != '0);

  assign pend_hazard = pending &
                       (((rs_addr != '0) && (rs_addr == pend_addr_q)) ||
                        ((rt_addr != '0) && (rt_addr == pend_addr_q)));

`ifdef REGFILE_BYPASS_EN
  assign stage_hazard = 1'b0;
`else
  assign stage_hazard = stage_valid_q &
                        (((rs_addr != '0) && (rs_addr == stage_addr_q)) ||
                         ((rt_addr != '0) && (rt_addr == stage_addr_q)));
`endif

  // A returning load owns the stage this cycle, so a same-cycle ALU/link
  // write must retry; a second load waits for the first to return.
  always_comb begin
    stall = pend_hazard | stage_hazard |
            (pending & wr_req & is_load) |
            (mem_accept & wr_req & ~is_load);
  end

  assign wr_issue = wr_req & ~stall;

  always_comb begin
    ld_state_d    = ld_state_q;
    pend_addr_d   = pend_addr_q;
    stage_valid_d = 1'b0;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    if (mem_accept) begin
      ld_state_d    = LD_IDLE;
      stage_valid_d = 1'b1;
      stage_addr_d  = pend_addr_q;
      stage_data_d  = read_data;
    end else if (wr_issue && !is_load) begin
      stage_valid_d = 1'b1;
      stage_addr_d  = dest;
      stage_data_d  = wb_result;
    end
    if (wr_issue && is_load) begin
      ld_state_d  = LD_WAIT;
      pend_addr_d = dest;
    end
  end

  // Reads: register 0 is hard zero; the stage holds the newest value of its
  // register, so it wins over the array whenever forwarding is enabled.
  always_comb begin
    src_a      = regs_q[rs_addr];
    write_data = regs_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (stage_valid_q && (rs_addr == stage_addr_q)) src_a      = stage_data_q;
    if (stage_valid_q && (rt_addr == stage_addr_q)) write_data = stage_data_q;
`else
`endif
    if (rs_addr == '0) src_a      = '0;
    if (rt_addr == '0) write_data = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      ld_state_q    <= LD_IDLE;
      pend_addr_q   <= '0;
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
    end else begin
      if (stage_valid_q) regs_q[stage_addr_q] <= stage_data_q;
      ld_state_q    <= ld_state_d;
      pend_addr_q   <= pend_addr_d;
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_unit.sv
module tb_regfile_wb_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        ext_mode;
  logic [31:0] alu_result;
  logic [31:0] read_data;
  logic        mem_valid;
  logic [31:0] pc_plus4;
  logic [31:0] src_a;
  logic [31:0] write_data;
  logic [31:0] imm_ext;
  logic        stall;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_wb_unit #(.DATA_W(32), .NUM_REGS(32), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .instr(instr), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .ext_mode(ext_mode),
    .alu_result(alu_result), .read_data(read_data), .mem_valid(mem_valid),
    .pc_plus4(pc_plus4), .src_a(src_a), .write_data(write_data),
    .imm_ext(imm_ext), .stall(stall)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_val: architectural value; a write "lands" at the edge it enters the
  // stage. m_old keeps the value before the latest landing, which is what a
  // non-forwarding read still sees during the cycle right after that landing.
  logic [31:0] m_val [32];
  logic [31:0] m_old [32];
  int          m_land [32];
  bit          m_pend;
  int          m_pa;
  int          cyc = 0;

  function automatic int f_rs(); return int'(instr[25:21]); endfunction
  function automatic int f_rt(); return int'(instr[20:16]); endfunction

  function automatic int m_dest();
    if (reg_dst == 2'd1) return int'(instr[15:11]);
    if (reg_dst == 2'd2) return 31;
    return int'(instr[20:16]);
  endfunction

  function automatic bit m_fresh(int a);
    return (a != 0) && (m_land[a] == cyc);
  endfunction

  function automatic bit m_stall();
    int d   = m_dest();
    bit wr  = reg_write && (d != 0);
    bit ld  = (mem_to_reg == 2'd1);
    bit s   = 1'b0;
    int rs  = f_rs();
    int rt  = f_rt();
    if (m_pend && ((rs != 0 && rs == m_pa) || (rt != 0 && rt == m_pa))) s = 1'b1;
    if (m_pend && wr && ld) s = 1'b1;
    if (m_pend && mem_valid && wr && !ld) s = 1'b1;
    if (!BYP && (m_fresh(rs) || m_fresh(rt))) s = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_read(int a);
    if (a == 0) return 32'h0;
    if (!BYP && m_land[a] == cyc) return m_old[a];
    return m_val[a];
  endfunction

  function automatic logic [31:0] m_imm();
    logic signed [15:0] s16;
    s16 = instr[15:0];
    if (ext_mode) return 32'(instr[15:0]);
    return 32'(s16);
  endfunction

  task automatic m_write(int a, logic [31:0] v);
    m_old[a]  = m_val[a];
    m_val[a]  = v;
    m_land[a] = cyc + 1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'h0; m_old[i] = 32'h0; m_land[i] = -100;
      end
      m_pend = 1'b0;
      m_pa   = 0;
    end else begin
      bit s;
      int d;
      bit iss;
      s   = m_stall();
      d   = m_dest();
      iss = reg_write && !s && (d != 0);
      if (m_pend && mem_valid) begin
        m_write(m_pa, read_data);
        m_pend = 1'b0;
      end
      if (iss && mem_to_reg == 2'd1) begin
        m_pend = 1'b1;
        m_pa   = d;
      end else if (iss) begin
        m_write(d, (mem_to_reg == 2'd2) ? pc_plus4 : alu_result);
      end
      cyc++;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_src_a", src_a, m_read(f_rs()));
      chk("cmp_write_data", write_data, m_read(f_rt()));
      chk("cmp_imm_ext", imm_ext, m_imm());
      chk("cmp_stall", {31'h0, stall}, {31'h0, m_stall()});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic look(); #2; endtask

  task automatic idle();
    instr = 32'h0; reg_write = 1'b0; reg_dst = 2'd0; mem_to_reg = 2'd0;
    ext_mode = 1'b0; alu_result = 32'h0; read_data = 32'h0;
    mem_valid = 1'b0; pc_plus4 = 32'h0;
  endtask

  task automatic ctl(logic rw, logic [1:0] dst, logic [1:0] m2r);
    reg_write = rw; reg_dst = dst; mem_to_reg = m2r;
  endtask

  task automatic set_i(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [10:0] lo);
    instr = {6'd0, rs, rt, rd, lo};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    idle();
    #1 reset = 1'b1;
    started = 1'b1;
    tick();
    // Reset state and immediate extension
    instr = {6'd0, 5'd5, 5'd9, 16'h8000};
    look();
    chk("rst_imm_sext", imm_ext, 32'hFFFF8000);
    chk("rst_src_a", src_a, 32'h0);
    chk("rst_wdata", write_data, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    tick();
    ext_mode = 1'b1;
    look();
    chk("rst_imm_zext", imm_ext, 32'h00008000);
    tick();
    reset = 1'b0;
    idle();
    tick();

    // ALU write to r5 via rd, then dependent read
    ctl(1, 2'd1, 2'd0); set_i(0, 0, 5, 0); alu_result = 32'h1234ABCD;
    tick();
    idle(); set_i(5, 0, 0, 0);
`ifdef REGFILE_BYPASS_EN
    look(); chk("r5_bypass", src_a, 32'h1234ABCD); chk("r5_nostall", {31'h0, stall}, 32'h0);
    tick();
`else
    look(); chk("r5_hold", {31'h0, stall}, 32'h1);
    tick();
    look(); chk("r5_array", src_a, 32'h1234ABCD); chk("r5_release", {31'h0, stall}, 32'h0);
    tick();
`endif
    look(); chk("r5_later", src_a, 32'h1234ABCD);
    tick();

    // Write to r0 is dropped
    ctl(1, 2'd0, 2'd0); set_i(0, 0, 0, 0); alu_result = 32'hDEADBEEF;
    tick();
    idle(); set_i(0, 0, 0, 0);
    look(); chk("r0_zero", src_a, 32'h0); chk("r0_nostall", {31'h0, stall}, 32'h0);
    tick();

    // Load to r7 with a dependent reader
    ctl(1, 2'd0, 2'd1); set_i(0, 7, 0, 0);
    tick();
    idle(); set_i(7, 0, 0, 0);
    look(); chk("ld_dep0", {31'h0, stall}, 32'h1);
    tick();
    look(); chk("ld_dep1", {31'h0, stall}, 32'h1);
    tick();
    mem_valid = 1'b1; read_data = 32'h00000042;
    look(); chk("ld_dep_ret", {31'h0, stall}, 32'h1);
    tick();
    mem_valid = 1'b0; read_data = 32'h0;
`ifndef REGFILE_BYPASS_EN
    look(); chk("ld_dep_stage", {31'h0, stall}, 32'h1);
    tick();
`endif
    look(); chk("ld_r7", src_a, 32'h00000042); chk("ld_free", {31'h0, stall}, 32'h0);
    tick();

    // Second load while pending, then a returning load vs an ALU write
    ctl(1, 2'd0, 2'd1); set_i(0, 7, 0, 0);
    tick();
    ctl(1, 2'd0, 2'd1); set_i(0, 9, 0, 0);
    look(); chk("ld_second", {31'h0, stall}, 32'h1);
    tick();
    ctl(1, 2'd1, 2'd0); set_i(0, 0, 3, 0); alu_result = 32'h00000033;
    mem_valid = 1'b1; read_data = 32'h00000077;
    look(); chk("alu_vs_mem", {31'h0, stall}, 32'h1);
    tick();
    mem_valid = 1'b0; read_data = 32'h0;
    look(); chk("alu_retry", {31'h0, stall}, 32'h0);
    tick();
    idle(); set_i(7, 3, 0, 0);
`ifndef REGFILE_BYPASS_EN
    tick();
`endif
    look(); chk("both_r7", src_a, 32'h00000077); chk("both_r3", write_data, 32'h00000033);
    tick();

    // Back-to-back writes to r4: newest value must survive
    ctl(1, 2'd1, 2'd0); set_i(0, 0, 4, 0); alu_result = 32'hAAAA0001;
    tick();
    alu_result = 32'hBBBB0002;
    tick();
    idle(); set_i(4, 4, 0, 0);
`ifndef REGFILE_BYPASS_EN
    tick();
`endif
    look(); chk("r4_newest", src_a, 32'hBBBB0002);
    tick();
    look(); chk("r4_settled", write_data, 32'hBBBB0002);
    tick();

    // jal link write
    ctl(1, 2'd2, 2'd2); set_i(0, 0, 0, 0); pc_plus4 = 32'h00400010; alu_result = 32'hFFFFFFFF;
    tick();
    idle(); set_i(31, 0, 0, 0);
`ifndef REGFILE_BYPASS_EN
    tick();
`endif
    look(); chk("jal_link", src_a, 32'h00400010);
    tick();

    // Sweep of writes and cross reads, immediates varied
    for (int i = 1; i <= 12; i++) begin
      logic [4:0] r;
      r = 5'(i);
      ctl(1, 2'd1, 2'd0); set_i(0, 0, r, 11'(i * 37));
      alu_result = (32'h01010101 * i) ^ 32'hA5000000;
      ext_mode = i[0];
      tick();
    end
    for (int i = 1; i <= 12; i++) begin
      logic [4:0] a;
      logic [4:0] b;
      a = 5'(i);
      b = 5'(13 - i);
      idle(); set_i(a, b, 5'(i + 3), 11'(i * 151)); instr[15] = i[1];
      ext_mode = i[0];
      tick();
    end
    idle(); set_i(3, 10, 0, 0);
    look(); chk("sweep_r3", src_a, (32'h01010101 * 3) ^ 32'hA5000000);
    chk("sweep_r10", write_data, (32'h01010101 * 10) ^ 32'hA5000000);
    tick();

    // Reset while a load is outstanding
    ctl(1, 2'd0, 2'd1); set_i(0, 10, 0, 0);
    tick();
    idle(); set_i(5, 7, 0, 0);
    reset = 1'b1;
    look(); chk("mid_rst_r5", src_a, 32'h0); chk("mid_rst_r7", write_data, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    tick();
    reset = 1'b0;
    set_i(10, 0, 0, 0); mem_valid = 1'b1; read_data = 32'h00000BAD;
    look(); chk("stale_ret_stall", {31'h0, stall}, 32'h0);
    tick();
    mem_valid = 1'b0; read_data = 32'h0;
    look(); chk("stale_ret_r10", src_a, 32'h0);
    tick();
    tick();

    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_unit.md
Name: regfile_wb_unit

Overview:
- Parametrised successor of the datapath register-file front end.
- Per instruction: decodes source and destination registers, reads two operands and produces the extended immediate.
- Writeback is registered one stage behind decode, with a write-through bypass to the read ports.
- A single-outstanding-load scoreboard stalls decode until delayed memory data returns.
- Sits between instruction fetch/decode and the ALU / data-memory path of the single-issue MIPS core.

Parameters:
- DATA_W, 32: operand/result width; must be >= 16.
- NUM_REGS, 32: architectural register count; power of two, 2..32. ADDR_W = log2(NUM_REGS). Register specifiers are the low ADDR_W bits of the instruction fields.
- LINK_REG, NUM_REGS-1: destination selected by reg_dst=2 (jal link).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-high.
- instr  in  32  current instruction; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- reg_write  in  1  instruction writes a register.
- reg_dst  in  2  destination select: 0 rt, 1 rd, 2 LINK_REG, 3 reserved (treated as 0).
- mem_to_reg  in  2  result select: 0 alu_result, 1 memory (load path), 2 pc_plus4, 3 reserved (treated as 0).
- ext_mode  in  1  immediate extension: 0 sign-extend, 1 zero-extend.
- alu_result  in  DATA_W  ALU output.
- read_data  in  DATA_W  data-memory output, qualified by mem_valid.
- mem_valid  in  1  read_data valid this cycle for the outstanding load.
- pc_plus4  in  DATA_W  link value.
- src_a  out  DATA_W  rs operand.
- write_data  out  DATA_W  rt operand.
- imm_ext  out  DATA_W  extended imm.
- stall  out  1  decode must hold instr; no state update for this instruction.

Behaviour:
- Reset (async): all registers = 0, wb stage invalid, pending load cleared, stall = 0. src_a and write_data read 0. imm_ext is purely combinational from instr.
- Register 0 always reads 0. Writes to register 0 are dropped: no wb stage entry, no pending mark.
- Reads are combinational. Priority: addr 0 → 0; else wb stage valid and addr match → wb_data (bypass); else array.
- Issue = reg_write & !stall & (dest != 0).
- Issue with mem_to_reg != 1: the next clk loads the wb stage {addr, data, valid=1}; the cycle after, the array is written. Write latency is 1 cycle into the stage, visible via bypass immediately after that edge.
- Issue with mem_to_reg = 1: the next clk sets pending = 1 and pend_addr = dest. No stage entry.
- mem_valid with pending: the next clk loads the wb stage with {pend_addr, read_data} and clears pending. mem_valid without pending is ignored.
- stall = 1 when any of the following holds:
  - pending and rs or rt (nonzero) equals pend_addr;
  - pending and the instruction is a load issue (single outstanding load);
  - mem_valid and an ALU/link issue in the same cycle (the stage is taken by the load; the instruction retries next cycle).
- Wb stage is invalid in any cycle in which neither source loaded it. Its array write still completes.
- stall is combinational and depends only on current inputs plus pending/stage state.
- Same-cycle read of the register currently in the stage returns the stage data. The array write of an older value never overrides a newer stage value.
- Reset mid-load: pending is discarded. A later mem_valid is ignored.
- imm_ext = {DATA_W-16 copies of imm[15] or 0 per ext_mode, imm}.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: stage-to-read bypass as above.
- Undefined: no bypass path. stall is additionally asserted when the wb stage is valid and rs or rt (nonzero) matches the stage address. Reads always come from the array.

Test Plan:
- reset=1 mid-run, then release → src_a=write_data=0 for every rs/rt; stall=0; imm=0x8000 with ext_mode=0 gives imm_ext=0xFFFF8000, with ext_mode=1 gives 0x00008000.
- ALU write rd=5 with 0x1234ABCD (reg_dst=1), next instr reads rs=5 → src_a=0x1234ABCD in the cycle after the edge (bypass); two cycles later, with the bypass macro undefined, the same value comes from the array after 1 stall cycle.
- Write 0xDEADBEEF to rt=0 → src_a for rs=0 stays 0; no stage entry.
- Load to r7, dependent instr rs=7 → stall=1 until mem_valid with read_data=0x00000042; next cycle stall=0, src_a=0x42.
- Pending load plus a second load issue → stall=1; mem_valid coincident with an ALU write to r3 → ALU instruction stalled 1 cycle; both r7 and r3 are written correctly.
- jal: reg_dst=2, mem_to_reg=2, pc_plus4=0x00400010 → register LINK_REG reads 0x00400010.
